// File: rtl/target_manager_pkg.sv
// rtl/target_manager_pkg.sv - shared FSM states, LFSR constants and screen limits for the target game blocks
package target_manager_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_ACK,
    ST_RELOCATE,
    ST_COOLDOWN
  } tm_state_e;

  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_MARGIN = 50;
  localparam int Y_MARGIN = 50;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/target_manager_lfsr16.sv
// rtl/target_manager_lfsr16.sv - free-running 16-bit Fibonacci LFSR, advances every clock
module lfsr16
  import target_manager_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [LFSR_W-1:0] state
);

  // An all-zero seed would lock the register, so fall back to the default
  localparam logic [LFSR_W-1:0] RESET_VAL = (SEED == '0) ? LFSR_DEFAULT_SEED : SEED;

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/target_manager.sv
// rtl/target_manager.sv - qualifies hits over frames, acknowledges, scores and relocates the target
module target_manager
  import target_manager_pkg::*;
#(
  parameter int                HIT_FRAMES      = 3,
  parameter int                COOLDOWN_FRAMES = 30,
  parameter int                X_MIN           = X_MARGIN,
  parameter int                X_MAX           = SCREEN_W - X_MARGIN,
  parameter int                Y_MIN           = Y_MARGIN,
  parameter int                Y_MAX           = SCREEN_H - Y_MARGIN,
  parameter int                X_INIT          = SCREEN_W / 2,
  parameter int                Y_INIT          = SCREEN_H / 2,
  parameter int                TARGET_SIZE     = 50,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = LFSR_DEFAULT_SEED,
  parameter int                RELOCATE_MAX    = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        hit,
  output logic        hitAck,
  output logic [11:0] targetCoord_X,
  output logic [11:0] targetCoord_Y,
  output logic [7:0]  targetSize,
  output logic [15:0] score,
  output logic        busy
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] HIT_N      = CNT_W'(HIT_FRAMES);
  localparam logic [CNT_W-1:0] COOL_N     = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] RELOC_LAST = CNT_W'(RELOCATE_MAX - 1);
  localparam logic [11:0]      X_BASE     = 12'(X_MIN);
  localparam logic [11:0]      Y_BASE     = 12'(Y_MIN);
  localparam logic [11:0]      X_SPAN     = 12'(X_MAX - X_MIN);
  localparam logic [11:0]      Y_SPAN     = 12'(Y_MAX - Y_MIN);

  tm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  reloc_q, reloc_d;
  logic              x_done_q, x_done_d;
  logic              y_done_q, y_done_d;
  logic [11:0]       x_q, x_d;
  logic [11:0]       y_q, y_d;
  logic [15:0]       score_q, score_d;
  logic [LFSR_W-1:0] lfsr;

  logic [11:0] cand_x, cand_y;
  logic        x_ok, y_ok, reloc_last;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .resetn(resetn),
    .state (lfsr)
  );

  assign cand_x     = {2'b00, lfsr[9:0]};
  assign cand_y     = {3'b000, lfsr[15:7]};
  assign x_ok       = (cand_x <= X_SPAN);
  assign y_ok       = (cand_y <= Y_SPAN);
  assign reloc_last = (reloc_q == RELOC_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reloc_d  = reloc_q;
    x_done_d = x_done_q;
    y_done_d = y_done_q;
    x_d      = x_q;
    y_d      = y_q;
    score_d  = score_q;

    case (state_q)
      ST_IDLE: begin
        if (enable && frame_tick && hit) begin
          if (HIT_FRAMES <= 1) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_QUALIFY;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      ST_QUALIFY: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (!hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q + CNT_W'(1) >= HIT_N) begin
            state_d = ST_ACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_ACK: begin
        score_d  = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
        x_done_d = 1'b0;
        y_done_d = 1'b0;
        reloc_d  = '0;
        state_d  = ST_RELOCATE;
      end

      ST_RELOCATE: begin
        reloc_d = reloc_q + CNT_W'(1);
        // Rejection sampling per axis; on timeout an out-of-range candidate is clamped to the span
        if (!x_done_q && (x_ok || reloc_last)) begin
          x_d      = X_BASE + (x_ok ? cand_x : X_SPAN);
          x_done_d = 1'b1;
        end
        if (!y_done_q && (y_ok || reloc_last)) begin
          y_d      = Y_BASE + (y_ok ? cand_y : Y_SPAN);
          y_done_d = 1'b1;
        end
        if (((x_done_q || x_ok) && (y_done_q || y_ok)) || reloc_last) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
        end
      end

      ST_COOLDOWN: begin
        // A hit still held past the cooldown keeps us here so one overlap scores once
        if (cnt_q >= COOL_N && !hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (frame_tick && cnt_q < COOL_N) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reloc_q  <= '0;
      x_done_q <= 1'b0;
      y_done_q <= 1'b0;
      x_q      <= 12'(X_INIT);
      y_q      <= 12'(Y_INIT);
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reloc_q  <= reloc_d;
      x_done_q <= x_done_d;
      y_done_q <= y_done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      score_q  <= score_d;
    end
  end

  assign hitAck        = (state_q == ST_ACK);
  assign busy          = (state_q != ST_IDLE);
  assign targetCoord_X = x_q;
  assign targetCoord_Y = y_q;
  assign score         = score_q;
  assign targetSize    = 8'(TARGET_SIZE);

endmodule

// File: tb/tb_target_manager.sv
// tb/tb_target_manager.sv - directed and randomized checks of target_manager against a frame-level model
module tb_target_manager;

  localparam int HIT_FRAMES      = 3;
  localparam int COOLDOWN_FRAMES = 30;
  localparam int X_MIN           = 50;
  localparam int X_MAX           = 590;
  localparam int Y_MIN           = 50;
  localparam int Y_MAX           = 430;
  localparam int RELOCATE_MAX    = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic        hit = 1'b0;
  logic        hitAck;
  logic [11:0] targetCoord_X;
  logic [11:0] targetCoord_Y;
  logic [7:0]  targetSize;
  logic [15:0] score;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  target_manager dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .hit          (hit),
    .hitAck       (hitAck),
    .targetCoord_X(targetCoord_X),
    .targetCoord_Y(targetCoord_Y),
    .targetSize   (targetSize),
    .score        (score),
    .busy         (busy)
  );

  // Model: a game phase plus a streak of consecutive hit frames while waiting
  typedef enum int {M_WAIT, M_ACK, M_RELOC, M_COOL} mphase_e;
  mphase_e     m_phase;
  int          m_streak, m_age, m_cool, m_x, m_y, m_score;
  bit          m_xd, m_yd;
  logic [15:0] m_lfsr;
  int          taps[4] = '{16, 14, 13, 11};

  function automatic logic [15:0] shift_lfsr(input logic [15:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i]-1];
    return {s[14:0], fb};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_WAIT;
    m_streak = 0;
    m_age    = 0;
    m_cool   = 0;
    m_x      = 320;
    m_y      = 240;
    m_score  = 0;
    m_xd     = 1'b0;
    m_yd     = 1'b0;
    m_lfsr   = 16'hACE1;
  endtask

  task automatic model_step();
    int cx, cy, sx, sy;
    sx = X_MAX - X_MIN;
    sy = Y_MAX - Y_MIN;
    case (m_phase)
      M_WAIT: begin
        if (!enable) m_streak = 0;
        else if (frame_tick) m_streak = hit ? m_streak + 1 : 0;
        if (m_streak >= HIT_FRAMES) begin
          m_phase  = M_ACK;
          m_streak = 0;
        end
      end
      M_ACK: begin
        if (m_score < 65535) m_score++;
        m_phase = M_RELOC;
        m_age   = 0;
        m_xd    = 1'b0;
        m_yd    = 1'b0;
      end
      M_RELOC: begin
        cx = int'(m_lfsr) % 1024;
        cy = int'(m_lfsr) / 128;
        m_age++;
        if (!m_xd && cx <= sx) begin m_x = X_MIN + cx; m_xd = 1'b1; end
        if (!m_yd && cy <= sy) begin m_y = Y_MIN + cy; m_yd = 1'b1; end
        if (m_xd && m_yd) begin
          m_phase = M_COOL;
          m_cool  = 0;
        end else if (m_age == RELOCATE_MAX) begin
          if (!m_xd) m_x = X_MIN + ((cx < sx) ? cx : sx);
          if (!m_yd) m_y = Y_MIN + ((cy < sy) ? cy : sy);
          m_phase = M_COOL;
          m_cool  = 0;
        end
      end
      M_COOL: begin
        if (m_cool >= COOLDOWN_FRAMES && !hit) m_phase = M_WAIT;
        else if (frame_tick) m_cool++;
      end
      default: m_phase = M_WAIT;
    endcase
    m_lfsr = shift_lfsr(m_lfsr);
  endtask

  task automatic compare();
    chk("hitAck", int'(hitAck), int'(m_phase == M_ACK));
    chk("busy", int'(busy), int'(m_phase != M_WAIT || m_streak > 0));
    chk("targetCoord_X", int'(targetCoord_X), m_x);
    chk("targetCoord_Y", int'(targetCoord_Y), m_y);
    chk("score", int'(score), m_score);
    chk("targetSize", int'(targetSize), 50);
    if (hitAck) ack_cnt++;
    if (busy) busy_cnt++;
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    if (resetn) model_step();
    @(negedge clk);
    if (resetn) compare();
  endtask

  task automatic frame(input logic h, input logic e);
    hit        = h;
    enable     = e;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && busy; k++) frame(1'b0, 1'b1);
    chk("wait_idle_bound", int'(busy), 0);
  endtask

  int a0, b0;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_X", int'(targetCoord_X), 320);
    chk("reset_Y", int'(targetCoord_Y), 240);
    chk("reset_score", int'(score), 0);
    chk("reset_hitAck", int'(hitAck), 0);
    chk("reset_busy", int'(busy), 0);
    resetn = 1'b1;
    repeat (5) cycle();

    // Qualified hit
    a0 = ack_cnt;
    repeat (3) frame(1'b1, 1'b1);
    chk("first_hit_acks", ack_cnt - a0, 1);
    wait_idle();
    chk("first_hit_score", int'(score), 1);
    chk("first_hit_x_range", int'(targetCoord_X >= 12'd50 && targetCoord_X <= 12'd590), 1);
    chk("first_hit_y_range", int'(targetCoord_Y >= 12'd50 && targetCoord_Y <= 12'd430), 1);

    // Glitch on the third frame
    a0 = ack_cnt;
    frame(1'b1, 1'b1);
    frame(1'b1, 1'b1);
    frame(1'b0, 1'b1);
    chk("glitch_acks", ack_cnt - a0, 0);
    chk("glitch_score", int'(score), 1);
    chk("glitch_busy", int'(busy), 0);

    // Sustained overlap scores once
    a0 = ack_cnt;
    repeat (100) frame(1'b1, 1'b1);
    chk("sustained_acks", ack_cnt - a0, 1);
    chk("sustained_busy", int'(busy), 1);
    hit = 1'b0;
    cycle();
    chk("drop_to_idle", int'(busy), 0);

    // Disabled game ignores hits, then needs three fresh frames
    a0 = ack_cnt;
    b0 = busy_cnt;
    repeat (10) frame(1'b1, 1'b0);
    chk("disabled_acks", ack_cnt - a0, 0);
    chk("disabled_busy", busy_cnt - b0, 0);
    repeat (2) frame(1'b1, 1'b1);
    chk("reenable_two_frames", ack_cnt - a0, 0);
    frame(1'b1, 1'b1);
    chk("reenable_third_frame", ack_cnt - a0, 1);
    wait_idle();

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) hit = ~hit;
      enable = ($urandom_range(0, 19) != 0);
      cycle();
    end
    frame_tick = 1'b0;
    hit        = 1'b0;
    enable     = 1'b1;
    cycle();
    wait_idle();

    // Score saturation
    force dut.score_q = 16'hFFFE;
    m_score = 16'hFFFE;
    cycle();
    release dut.score_q;
    a0 = ack_cnt;
    repeat (2) begin
      repeat (3) frame(1'b1, 1'b1);
      wait_idle();
    end
    chk("saturated_acks", ack_cnt - a0, 2);
    chk("saturated_score", int'(score), 16'hFFFF);

    // Reset during relocation
    repeat (2) frame(1'b1, 1'b1);
    hit        = 1'b1;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("pre_reset_ack", int'(hitAck), 1);
    cycle();
    chk("pre_reset_busy", int'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("async_reset_X", int'(targetCoord_X), 320);
    chk("async_reset_Y", int'(targetCoord_Y), 240);
    chk("async_reset_score", int'(score), 0);
    chk("async_reset_hitAck", int'(hitAck), 0);
    chk("async_reset_busy", int'(busy), 0);
    model_reset();
    hit = 1'b0;
    repeat (2) cycle();
    resetn = 1'b1;
    repeat (3) cycle();
    repeat (3) frame(1'b1, 1'b1);
    wait_idle();
    chk("post_reset_score", int'(score), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
